// File: rtl/fb_pixel_packer_pkg.sv
// -----------------------------------------------------------------------------
// fb_pixel_packer_pkg
// Shared types and helpers for the framebuffer pixel packer.
//   fb_word_t      : one framebuffer write {addr, data, mask}
//   coal_state_t   : coalescing-stage state encoding
//   lane_data      : palette value shifted into its 2-bit lane
//   lane_bits      : 2-bit field mask for a lane
//   lane_onehot    : write-mask bit for a lane
// -----------------------------------------------------------------------------
package fb_pixel_packer_pkg;

    localparam int PIXELS_PER_WORD = 16;

    // Widest word address carried through the FIFO; the top truncates to its
    // own ADDR_WIDTH, which must not exceed this.
    localparam int FB_ADDR_WIDTH = 15;

    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] addr;
        logic [31:0]              data;
        logic [15:0]              mask;
    } fb_word_t;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_PEND       = 2'd1,
        ST_PEND_FLUSH = 2'd2
    } coal_state_t;

    function automatic logic [31:0] lane_data(input logic [1:0] pal, input logic [3:0] lane);
        return 32'(pal) << {lane, 1'b0};
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] lane);
        return 32'h3 << {lane, 1'b0};
    endfunction

    function automatic logic [15:0] lane_onehot(input logic [3:0] lane);
        return 16'h1 << lane;
    endfunction

endpackage

// File: rtl/fb_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// fb_pixel_packer_if
// Word output bus from the packer to the framebuffer memory controller.
//   out_valid  : head word valid
//   out_ready  : controller accepts the head this cycle
//   out_addr   : word address
//   out_data   : 16 x 2-bit pixels, lane i at [2i+1:2i]
//   out_mask   : lane write enables
// master = packer side, slave = controller side.
// -----------------------------------------------------------------------------
interface fb_pixel_packer_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [31:0]           out_data;
    logic [15:0]           out_mask;

    modport master (
        output out_valid, out_addr, out_data, out_mask,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_addr, out_data, out_mask,
        output out_ready
    );
endinterface

// File: rtl/fb_word_fifo.sv
// -----------------------------------------------------------------------------
// fb_word_fifo
// Synchronous FIFO of fb_word_t. Head is read straight from registered storage.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the caller is expected to treat it as dropped.
//   clk_33m, rst      : clock, synchronous active-high reset
//   push / push_word  : write request and data
//   pop               : remove head (ignored when empty)
//   head              : current head word
//   full / empty      : status
//   count             : number of stored words
// -----------------------------------------------------------------------------
module fb_word_fifo
    import fb_pixel_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_33m,
    input  logic                       rst,
    input  logic                       push,
    input  fb_word_t                   push_word,
    input  logic                       pop,
    output fb_word_t                   head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fb_word_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_33m) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end

endmodule

// File: rtl/fb_pixel_packer.sv
// -----------------------------------------------------------------------------
// fb_pixel_packer
// Packs the painter pixel stream (x, y, 2-bit palette) into 32-bit masked
// framebuffer words of 16 pixels, coalescing runs that hit the same word and
// clipping off-screen pixels. Finished words go through a small FIFO to the
// framebuffer controller.
//   clk_33m, rst                 : clock, synchronous active-high reset
//   in_valid, write_x/y/palette  : pixel stream (cannot be stalled)
//   flush                        : end-of-frame pulse, emit pending word
//   out_if (master)              : word bus {valid, ready, addr, data, mask}
//   idle                         : nothing pending anywhere
//   overflow                     : sticky, a word was dropped on a full FIFO
//
// Pipeline: stage 1 (clip/address) -> stage 2 (coalesce) -> push register
// -> FIFO. Flush travels with stage 1 so it stays behind the last pixel.
//
// Coalescer states
//   state         | meaning
//   ST_EMPTY      | no pending word
//   ST_PEND       | pending word accumulating lanes
//   ST_PEND_FLUSH | pending word was flushed and must be pushed this cycle
//                 | (the previous cycle already used its single push slot)
// -----------------------------------------------------------------------------
module fb_pixel_packer
    import fb_pixel_packer_pkg::*;
#(
    parameter int COOR_WIDTH    = 12,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT / 16),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk_33m,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [COOR_WIDTH-1:0] write_x,
    input  logic [COOR_WIDTH-1:0] write_y,
    input  logic [1:0]            write_palette,
    input  logic                  flush,
    fb_pixel_packer_if.master     out_if,
    output logic                  idle,
    output logic                  overflow
);
    localparam int WORDS_PER_ROW = SCREEN_WIDTH / PIXELS_PER_WORD;
    localparam logic [COOR_WIDTH-1:0] X_LIMIT = COOR_WIDTH'(SCREEN_WIDTH);
    localparam logic [COOR_WIDTH-1:0] Y_LIMIT = COOR_WIDTH'(SCREEN_HEIGHT);

    // ---------------- stage 1: clip and address ----------------
    logic                     on_screen;
    logic [ADDR_WIDTH-1:0]    in_addr;
    logic                     s1_valid_q;
    logic                     s1_flush_q;
    logic [FB_ADDR_WIDTH-1:0] s1_addr_q;
    logic [3:0]               s1_lane_q;
    logic [1:0]               s1_pal_q;

    // Negative painter coordinates wrap to large unsigned values and clip here.
    assign on_screen = (write_x < X_LIMIT) && (write_y < Y_LIMIT);
    assign in_addr   = ADDR_WIDTH'(write_y) * ADDR_WIDTH'(WORDS_PER_ROW)
                     + ADDR_WIDTH'(write_x[COOR_WIDTH-1:4]);

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_flush_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_lane_q  <= '0;
            s1_pal_q   <= '0;
        end else begin
            s1_valid_q <= in_valid && on_screen;
            s1_flush_q <= flush;
            s1_addr_q  <= FB_ADDR_WIDTH'(in_addr);
            s1_lane_q  <= write_x[3:0];
            s1_pal_q   <= write_palette;
        end
    end

    // ---------------- stage 2: coalesce ----------------
    coal_state_t              state_q, state_d;
    logic [FB_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]              pend_data_q, pend_data_d;
    logic [15:0]              pend_mask_q, pend_mask_d;
    logic                     push_d, push_q;
    fb_word_t                 push_word_d, push_word_q;

    logic        same_addr;
    logic [31:0] fresh_data;
    logic [15:0] fresh_mask;
    logic [31:0] merged_data;
    logic [15:0] merged_mask;

    assign same_addr   = (pend_addr_q == s1_addr_q);
    assign fresh_data  = lane_data(s1_pal_q, s1_lane_q);
    assign fresh_mask  = lane_onehot(s1_lane_q);
    // Later pixel wins: clear the lane before OR-ing the new palette in.
    assign merged_data = (pend_data_q & ~lane_bits(s1_lane_q)) | fresh_data;
    assign merged_mask = pend_mask_q | fresh_mask;

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_mask_q <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_mask_q <= pend_mask_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (s1_valid_q && !s1_flush_q) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (s1_flush_q)
                    state_d = (s1_valid_q && !same_addr) ? ST_PEND_FLUSH : ST_EMPTY;
            end
            ST_PEND_FLUSH: begin
                if (s1_valid_q) state_d = s1_flush_q ? ST_PEND_FLUSH : ST_PEND;
                else            state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        push_d      = 1'b0;
        push_word_d = '{addr: pend_addr_q, data: pend_data_q, mask: pend_mask_q};
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_mask_d = pend_mask_q;
        case (state_q)
            ST_EMPTY: begin
                if (s1_valid_q) begin
                    if (s1_flush_q) begin
                        push_d      = 1'b1;
                        push_word_d = '{addr: s1_addr_q, data: fresh_data, mask: fresh_mask};
                    end else begin
                        pend_addr_d = s1_addr_q;
                        pend_data_d = fresh_data;
                        pend_mask_d = fresh_mask;
                    end
                end
            end
            ST_PEND: begin
                if (s1_valid_q && same_addr) begin
                    if (s1_flush_q) begin
                        push_d      = 1'b1;
                        push_word_d = '{addr: pend_addr_q, data: merged_data, mask: merged_mask};
                    end else begin
                        pend_data_d = merged_data;
                        pend_mask_d = merged_mask;
                    end
                end else if (s1_valid_q) begin
                    push_d      = 1'b1;
                    pend_addr_d = s1_addr_q;
                    pend_data_d = fresh_data;
                    pend_mask_d = fresh_mask;
                end else if (s1_flush_q) begin
                    push_d = 1'b1;
                end
            end
            ST_PEND_FLUSH: begin
                // Flushed word goes out regardless; any new pixel starts fresh.
                push_d = 1'b1;
                if (s1_valid_q) begin
                    pend_addr_d = s1_addr_q;
                    pend_data_d = fresh_data;
                    pend_mask_d = fresh_mask;
                end
            end
            default: ;
        endcase
    end

    // ---------------- output FIFO ----------------
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fb_word_t       fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           pop;
    logic           overflow_q;

    assign pop = out_if.out_valid && out_if.out_ready;

    fb_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_33m   (clk_33m),
        .rst       (rst),
        .push      (push_q),
        .push_word (push_word_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_33m) begin
        if (rst)                                 overflow_q <= 1'b0;
        else if (push_q && fifo_full && !pop)    overflow_q <= 1'b1;
    end

    // Storage is not reset, so the bus is forced to zero while empty.
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_addr  = fifo_empty ? '0 : ADDR_WIDTH'(fifo_head.addr);
    assign out_if.out_data  = fifo_empty ? '0 : fifo_head.data;
    assign out_if.out_mask  = fifo_empty ? '0 : fifo_head.mask;

    assign overflow = overflow_q;
    assign idle     = (state_q == ST_EMPTY) && !s1_valid_q && !s1_flush_q
                    && !push_q && (fifo_count == '0);

endmodule

// File: tb/tb_fb_pixel_packer.sv
module tb_fb_pixel_packer;

    logic        clk_33m = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] write_x;
    logic [11:0] write_y;
    logic [1:0]  write_palette;
    logic        flush;
    logic        idle;
    logic        overflow;

    fb_pixel_packer_if #(.ADDR_WIDTH(15)) ifc ();

    fb_pixel_packer dut (
        .clk_33m       (clk_33m),
        .rst           (rst),
        .in_valid      (in_valid),
        .write_x       (write_x),
        .write_y       (write_y),
        .write_palette (write_palette),
        .flush         (flush),
        .out_if        (ifc),
        .idle          (idle),
        .overflow      (overflow)
    );

    always #5 clk_33m = ~clk_33m;

    typedef struct {
        logic [14:0] addr;
        logic [31:0] data;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: compares every accepted word against the queue.
    always @(negedge clk_33m) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got addr=%0d mask=%h data=%h, none expected",
                         ifc.out_addr, ifc.out_mask, ifc.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ifc.out_addr !== mon_e.addr || ifc.out_data !== mon_e.data ||
                    ifc.out_mask !== mon_e.mask) begin
                    errors++;
                    $display("FAIL word: got addr=%0d mask=%h data=%h, want addr=%0d mask=%h data=%h",
                             ifc.out_addr, ifc.out_mask, ifc.out_data,
                             mon_e.addr, mon_e.mask, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic expect_word(input int addr, input logic [15:0] mask, input logic [31:0] data);
        exp_t e;
        e.addr = 15'(addr);
        e.mask = mask;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Presents one input cycle; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input int x, input int y, input int pal, input logic fl);
        in_valid      = v;
        write_x       = 12'(x);
        write_y       = 12'(y);
        write_palette = 2'(pal);
        flush         = fl;
        @(posedge clk_33m);
        #1;
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        quiet();
        n = 0;
        repeat (4) @(negedge clk_33m);
        while (!(idle && exp_q.size() == 0) && n < 200) begin
            @(negedge clk_33m);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: idle=%0b pending_expected=%0d after 200 cycles, want idle=1 and 0",
                     name, idle, exp_q.size());
        end
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        in_valid      = 1'b0;
        write_x       = '0;
        write_y       = '0;
        write_palette = '0;
        flush         = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk_33m);
        #1 rst = 1'b0;

        @(negedge clk_33m);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_out_addr",  64'(ifc.out_addr),  64'd0);
        check("rst_out_data",  64'(ifc.out_data),  64'd0);
        check("rst_out_mask",  64'(ifc.out_mask),  64'd0);
        check("rst_idle",      64'(idle),          64'd1);
        check("rst_overflow",  64'(overflow),      64'd0);
        @(posedge clk_33m);
        #1;

        // Full word, lanes 0..15, palette i%4.
        expect_word(0, 16'hFFFF, 32'hE4E4E4E4);
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 0, i % 4, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        wait_drain("full_word");

        // Address change splits words.
        expect_word(51, 16'h0003, 32'h0000000B);
        expect_word(52, 16'h0100, 32'h00010000);
        cyc(1'b1, 16, 1, 3, 1'b0);
        cyc(1'b1, 17, 1, 2, 1'b0);
        cyc(1'b1, 40, 1, 1, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        wait_drain("split");

        // Clipped pixels produce nothing.
        cyc(1'b1, 800, 0, 1, 1'b0);
        cyc(1'b1, 4095, 5, 2, 1'b0);
        cyc(1'b1, 0, 480, 3, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        wait_drain("clip");
        check("clip_idle", 64'(idle), 64'd1);

        // Same lane twice: later pixel wins.
        expect_word(0, 16'h0008, 32'h00000080);
        cyc(1'b1, 3, 0, 1, 1'b0);
        cyc(1'b1, 3, 0, 2, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        wait_drain("same_lane");

        // Different-address pixel coincident with flush: two words, back to back.
        expect_word(100, 16'h0001, 32'h00000001);
        expect_word(101, 16'h0001, 32'h00000002);
        cyc(1'b1, 0, 2, 1, 1'b0);
        cyc(1'b1, 16, 2, 2, 1'b1);
        wait_drain("flush_coincident");

        // Bottom-right corner, pixel and flush together: out_valid 3 cycles later.
        expect_word(23999, 16'h8000, 32'hC0000000);
        cyc(1'b1, 799, 479, 3, 1'b1);
        quiet();
        lat = 0;
        while (lat < 10) begin
            @(negedge clk_33m);
            lat++;
            if (ifc.out_valid) break;
        end
        check("latency", 64'(lat), 64'd3);
        wait_drain("corner");

        // Overflow: six words into a 4-deep FIFO with the controller stalled.
        ifc.out_ready = 1'b0;
        expect_word(0, 16'h0001, 32'h00000001);
        expect_word(1, 16'h0001, 32'h00000002);
        expect_word(0, 16'h0001, 32'h00000003);
        expect_word(1, 16'h0001, 32'h00000001);
        cyc(1'b1, 0, 0, 1, 1'b0);
        cyc(1'b1, 16, 0, 2, 1'b0);
        cyc(1'b1, 0, 0, 3, 1'b0);
        cyc(1'b1, 16, 0, 1, 1'b0);
        cyc(1'b1, 0, 0, 2, 1'b0);
        cyc(1'b1, 16, 0, 3, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        quiet();
        repeat (10) @(negedge clk_33m);
        check("ovf_flag",       64'(overflow),      64'd1);
        check("ovf_held_valid", 64'(ifc.out_valid), 64'd1);
        check("ovf_held_data",  64'(ifc.out_data),  64'h1);
        @(posedge clk_33m);
        #1 ifc.out_ready = 1'b1;
        wait_drain("ovf");
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset with two words buffered.
        ifc.out_ready = 1'b0;
        cyc(1'b1, 0, 3, 1, 1'b0);
        cyc(1'b1, 16, 3, 1, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1);
        quiet();
        repeat (8) @(negedge clk_33m);
        check("pre_rst_valid", 64'(ifc.out_valid), 64'd1);
        @(posedge clk_33m);
        #1 rst = 1'b1;
        @(posedge clk_33m);
        #1 rst = 1'b0;
        @(negedge clk_33m);
        check("mid_rst_valid",    64'(ifc.out_valid), 64'd0);
        check("mid_rst_idle",     64'(idle),          64'd1);
        check("mid_rst_overflow", 64'(overflow),      64'd0);
        ifc.out_ready = 1'b1;
        wait_drain("post_rst");
        repeat (10) @(negedge clk_33m);
        check("post_rst_no_word", 64'(ifc.out_valid), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
